wb_wait_state_ram: RTL

- Wishbone classic slave memory sitting directly downstream of the async-memory-to-Wishbone bridge; consumes its addr/data/sel/we/cyc/stb and returns data plus ack/err.
- Provides a byte-lane-writable word array with a programmable ack latency, so bridge timing can be exercised against realistic slow slaves.
- Decodes its own window and answers out-of-window accesses with err.
- Holds each cycle until the master drops stb, which guards against double-commit while the bridge's synchroniser-delayed stb is still high.

---
 rtl/wb_async_mem_pkg.sv | 14 +
 rtl/wb_byte_lane_ram.sv | 27 ++
 rtl/wb_wait_state_ram.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wb_async_mem_pkg.sv
// rtl/wb_async_mem_pkg.sv - shared constants and FSM encoding for the wait-state RAM slave
package wb_async_mem_pkg;

  localparam int SEL_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/wb_byte_lane_ram.sv
// rtl/wb_byte_lane_ram.sv - word array with per-byte write enables and registered read
module wb_byte_lane_ram
  import wb_async_mem_pkg::*;
#(
  parameter int DW     = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic [SEL_W-1:0]  we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout
);

  logic [DW-1:0] mem [2**MEM_AW];

  // Lane-masked write and registered read; a same-address read returns the pre-write word
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/wb_wait_state_ram.sv
// rtl/wb_wait_state_ram.sv - Wishbone classic slave RAM with programmable ack latency and window decode
module wb_wait_state_ram
  import wb_async_mem_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int MEM_AW = 10,
  parameter int WAIT   = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [DW-1:0]    wb_data_i,
  output logic [DW-1:0]    wb_data_o,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [SEL_W-1:0] wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o
);

  generate
    if (WAIT < 0 || WAIT > (2**CNT_W) - 1) begin : g_wait_range
      $error("wb_wait_state_ram: WAIT must be in 0..15");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             win_q, win_nxt;
  logic [DW-1:0]    rd_q;
  logic [DW-1:0]    ram_dout;
  logic [SEL_W-1:0] ram_we;
  logic             req;
  logic             in_win;
  logic             enter_resp;
  logic             win_now;
  logic             rd_hit;
  logic             unused_addr;

  assign req         = wb_cyc_i & wb_stb_i;
  assign in_win      = (wb_addr_i[AW-1:MEM_AW+2] == '0);
  assign unused_addr = ^wb_addr_i[1:0];

  // With zero wait states the window decision is made on the same edge that commits the access
  assign win_now = (state == ST_IDLE) ? in_win : win_q;

  // Next-state, countdown and commit strobe for the access sequencer
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    win_nxt    = win_q;
    enter_resp = 1'b0;
    ram_we     = '0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          win_nxt = in_win;
          cnt_nxt = CNT_W'(WAIT);
          if (WAIT == 0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RESP: state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!req) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (enter_resp && wb_we_i && win_now) begin
      ram_we = wb_sel_i;
    end
  end

  // Sequencer registers; reset abandons any access that has not reached its response edge
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      win_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      win_q <= win_nxt;
    end
  end

  assign rd_hit = (state == ST_RESP) && win_q && !wb_we_i;

  // Keep the last successfully read word visible after its ack cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rd_q <= '0;
    end else if (rd_hit) begin
      rd_q <= ram_dout;
    end
  end

  assign wb_data_o = rd_hit ? ram_dout : rd_q;
  assign wb_ack_o  = (state == ST_RESP) &  win_q;
  assign wb_err_o  = (state == ST_RESP) & ~win_q;
  assign wb_rty_o  = 1'b0;

  wb_byte_lane_ram #(
    .DW     (DW),
    .MEM_AW (MEM_AW)
  ) u_ram (
    .clk  (wb_clk_i),
    .we   (ram_we),
    .addr (wb_addr_i[MEM_AW+1:2]),
    .din  (wb_data_i),
    .dout (ram_dout)
  );

endmodule
